adder_seq_param: RTL

Parametrised multi-cycle ripple adder/subtractor with a start/done handshake; the next generation of the fixed 4-bit gate-level adder. Processes DIGIT bits per clock over WIDTH/DIGIT cycles, with a carry chain registered between digits. Adds subtract mode, external carry-in, carry-out and signed overflow. Sits behind the DPI-C task interface in the top-level bench as the hardware model driven from C.

---
 rtl/adder_seq_param.sv | 110 +++++++++++
 1 files changed

// File: rtl/adder_seq_param.sv
// Multi-cycle ripple adder/subtractor: DIGIT bits per clock over WIDTH/DIGIT cycles,
// carry registered between digits, start/done handshake, carry-out and signed overflow.
module adder_seq_param #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = $clog2(NDIG) + 1;
  localparam int unsigned DW   = DIGIT + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] a_dig, b_dig, sum;
  logic             c_next;
  logic             last;
  logic             dig_ovf;

  // Digit select as a constant-slice mux keyed on the counter.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (cnt_q == CW'(k)) begin
        a_dig = a_q[k*DIGIT +: DIGIT];
        b_dig = b_q[k*DIGIT +: DIGIT];
      end
    end
  end

  always_comb begin
    {c_next, sum} = {1'b0, a_dig} + {1'b0, b_dig} + DW'(carry_q);
    last          = (cnt_q == CW'(NDIG - 1));
    // Same-sign operands giving an opposite-sign sum; equals carry-in^carry-out of the MSB.
    dig_ovf       = (a_dig[DIGIT-1] == b_dig[DIGIT-1]) && (sum[DIGIT-1] != a_dig[DIGIT-1]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s       <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | ci;
            cnt_q   <= '0;
            s       <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
          end
        end
        RUN: begin
          for (int unsigned k = 0; k < NDIG; k++) begin
            if (cnt_q == CW'(k)) s[k*DIGIT +: DIGIT] <= sum;
          end
          carry_q <= c_next;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            co   <= c_next;
            ovf  <= dig_ovf;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
